// File: rtl/pc_pkg.sv
// Shared types for the program-counter slice: next-PC source encoding and default increment.
package pc_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_BRANCH,
    NPC_JUMP,
    NPC_RET,
    NPC_TRAP,
    NPC_HOLD
  } npc_sel_e;

  localparam int PC_INC_DEFAULT = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Request/status bundle between the control/branch logic (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump_valid;
  logic [XLEN-1:0] jump_target;
  logic            is_call;
  logic            is_ret;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_inc;
  logic            ras_empty;
  logic            ras_full;
  logic            misalign;

  modport master (
    output stall, branch_taken, branch_target, jump_valid, jump_target,
           is_call, is_ret, trap_valid, trap_vector,
    input  pc_out, pc_plus_inc, ras_empty, ras_full, misalign
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump_valid, jump_target,
           is_call, is_ret, trap_valid, trap_vector,
    output pc_out, pc_plus_inc, ras_empty, ras_full, misalign
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full, replace rewrites the top.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] stack_mem [RAS_DEPTH];
  logic [PW-1:0]   ptr_reg, ptr_next, top_idx, wr_idx;
  logic [CW-1:0]   count_reg, count_next;
  logic            wr_en;

  // ptr_reg is the next free slot, so the top lives one below it (mod depth)
  assign top_idx = ptr_reg - PW'(1);

  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = ptr_reg;
    if (replace && count_reg != '0) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push || replace) begin
      // replace on an empty stack degenerates to a push so the count ends at 1
      wr_en    = 1'b1;
      ptr_next = ptr_reg + PW'(1);
      if (count_reg != CW'(RAS_DEPTH))
        count_next = count_reg + CW'(1);
    end else if (pop && count_reg != '0) begin
      ptr_next   = top_idx;
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      stack_mem[wr_idx] <= push_data;
  end

  assign top   = stack_mem[top_idx];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(RAS_DEPTH));

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC selection and return-address stack.
// Optional PC_ALIGN_CHECK_EN rejects misaligned branch/jump/return targets and flags misalign.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = PC_INC_DEFAULT,
  parameter int              RAS_DEPTH    = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  logic [XLEN-1:0] pc_reg, pc_next, link, ras_top, target;
  logic            ras_empty, ras_full, misaligned, load_ok, redirect;
  npc_sel_e        sel;

  assign link = pc_reg + XLEN'(INC);

  always_comb begin
    sel = NPC_SEQ;
    if (bus.trap_valid)
      sel = NPC_TRAP;
    else if (bus.stall)
      sel = NPC_HOLD;
    else if (bus.jump_valid)
      sel = (bus.is_ret && !ras_empty) ? NPC_RET : NPC_JUMP;
    else if (bus.branch_taken)
      sel = NPC_BRANCH;
  end

  always_comb begin
    target = link;
    case (sel)
      NPC_BRANCH: target = bus.branch_target;
      NPC_JUMP:   target = bus.jump_target;
      NPC_RET:    target = ras_top;
      NPC_TRAP:   target = bus.trap_vector;
      default:    target = link;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_reg, misalign_next;

  assign misaligned = (sel inside {NPC_BRANCH, NPC_JUMP, NPC_RET}) &&
                      ((target & XLEN'(INC - 1)) != '0);

  always_comb begin
    misalign_next = misaligned;
    if (sel == NPC_HOLD)
      misalign_next = misalign_reg;
    else if (sel == NPC_TRAP)
      misalign_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_reg <= 1'b0;
    else
      misalign_reg <= misalign_next;
  end

  assign bus.misalign = misalign_reg;
`else
  assign misaligned   = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  // A rejected target suppresses RAS side effects along with the PC update
  assign load_ok  = (sel != NPC_TRAP) && (sel != NPC_HOLD) && !misaligned;
  assign redirect = load_ok && bus.jump_valid;

  always_comb begin
    pc_next = target;
    if (sel == NPC_HOLD || (sel != NPC_TRAP && misaligned))
      pc_next = pc_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_reg <= RESET_VECTOR;
    else
      pc_reg <= pc_next;
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (redirect && bus.is_call && !bus.is_ret),
    .pop       (redirect && bus.is_ret && !bus.is_call),
    .replace   (redirect && bus.is_call && bus.is_ret),
    .push_data (link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.pc_out      = pc_reg;
  assign bus.pc_plus_inc = link;
  assign bus.ras_empty   = ras_empty;
  assign bus.ras_full    = ras_full;

endmodule
